mmio_periph_bus: RTL and testbench

//  Memory-mapped peripheral bus behind the CPU data port for 0x8000-0x83FF.

---
 rtl/mmio_periph_bus_pkg.sv | 52 +++++
 rtl/mmio_periph_bus_if.sv | 13 +
 rtl/mmio_periph_bus_uart.sv | 137 +++++++++++++
 rtl/mmio_periph_bus.sv | 85 ++++++++
 tb/tb_mmio_periph_bus.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_periph_bus_pkg.sv
// Shared definitions for the 0x8000-0x83FF peripheral window: register offsets,
// status bit positions, FSM state types and the address decoder.
package mmio_periph_bus_pkg;

  localparam logic [15:0] ADDR_PAR_IN    = 16'h8000;
  localparam logic [15:0] ADDR_PAR_OUT   = 16'h8002;
  localparam logic [15:0] ADDR_UART_DATA = 16'h8300;
  localparam logic [15:0] ADDR_UART_STAT = 16'h8302;
  localparam logic [15:0] ADDR_UART_CTRL = 16'h8304;
  localparam logic [15:0] ADDR_IRQ_STAT  = 16'h8306;

  localparam int unsigned STAT_TX_BUSY = 0;
  localparam int unsigned STAT_RX_PEND = 1;

  localparam logic [15:0] IRQ_VECTOR_DEFAULT = 16'h0010;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PAR_IN,
    REG_PAR_OUT,
    REG_UART_DATA,
    REG_UART_STAT,
    REG_UART_CTRL,
    REG_IRQ_STAT
  } reg_sel_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Registers are word aligned, so address bit 0 never takes part in the match.
  function automatic reg_sel_e decode(input logic [15:0] addr);
    case ({addr[15:1], 1'b0})
      ADDR_PAR_IN:    return REG_PAR_IN;
      ADDR_PAR_OUT:   return REG_PAR_OUT;
      ADDR_UART_DATA: return REG_UART_DATA;
      ADDR_UART_STAT: return REG_UART_STAT;
      ADDR_UART_CTRL: return REG_UART_CTRL;
      ADDR_IRQ_STAT:  return REG_IRQ_STAT;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_periph_bus_if.sv
// CPU data-port side of the peripheral window: single-cycle word accesses.
interface mmio_periph_bus_if;
  logic        i_sel;
  logic        i_we;
  logic        i_re;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_rdy;

  modport master (output i_sel, i_we, i_re, i_addr, i_wdata, input o_rdata, o_rdy);
  modport slave  (input i_sel, i_we, i_re, i_addr, i_wdata, output o_rdata, o_rdy);
endinterface

// File: rtl/mmio_periph_bus_uart.sv
// 8N1 UART: TX shifter, 2-flop synchronised RX with mid-bit sampling, pending flag.
module mmio_periph_bus_uart
  import mmio_periph_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       rx_clr,
  output logic       tx_busy,
  output logic       rx_pending,
  output logic [7:0] rx_data,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  tx_state_e     tx_state;
  logic [8:0]    tx_sr;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  rx_state_e     rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [7:0]    rx_sr;
  logic [2:0]    rx_bit;
  logic [CW-1:0] rx_cnt;
  logic          _rx_pending;

  assign tx_busy    = (tx_state == TX_SEND);
  assign rx_pending = _rx_pending;

  // Start bit is driven on the load edge; tx_sr holds data then stop bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      tx_state  <= TX_IDLE;
      o_uart_tx <= 1'b1;
      tx_sr     <= '0;
      tx_bit    <= '0;
      tx_cnt    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_state  <= TX_SEND;
            o_uart_tx <= 1'b0;
            tx_sr     <= {1'b1, tx_data};
            tx_bit    <= '0;
            tx_cnt    <= '0;
          end
        end
        TX_SEND: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_state  <= TX_IDLE;
              o_uart_tx <= 1'b1;
            end else begin
              o_uart_tx <= tx_sr[0];
              tx_sr     <= {1'b0, tx_sr[8:1]};
              tx_bit    <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // The clear is scheduled first so a same-cycle frame completion overrides it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_sr       <= '0;
      rx_bit      <= '0;
      rx_cnt      <= '0;
      rx_data     <= '0;
      _rx_pending <= 1'b0;
    end else begin
      rx_s1   <= i_uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_clr) _rx_pending <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            rx_sr  <= {rx_s2, rx_sr[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_data     <= rx_sr;
              _rx_pending <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mmio_periph_bus.sv
// Peripheral window 0x8000-0x83FF: parallel port, UART and a single-vector
// interrupt controller behind a zero-wait-state word bus.
module mmio_periph_bus
  import mmio_periph_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [15:0] IRQ_VECTOR   = IRQ_VECTOR_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  mmio_periph_bus_if.slave       bus,
  input  logic [3:0]             i_par_i,
  output logic [3:0]             o_par_o,
  input  logic                   i_uart_rx,
  output logic                   o_uart_tx,
  input  logic                   i_in_irq,
  input  logic                   i_int_en,
  input  logic                   i_irq_ret,
  output logic                   o_irq_take,
  output logic [15:0]            o_irq_vector
);

  reg_sel_e   reg_sel;
  logic       wr, rd;
  logic       tx_busy, rx_pending;
  logic [7:0] rx_data;
  logic       rx_irq_en;
  logic       irq_armed;
  logic       irq_pend;
  logic       unused_bits;

  assign reg_sel     = decode(bus.i_addr);
  assign wr          = bus.i_sel & bus.i_we;
  assign rd          = bus.i_sel & bus.i_re;
  assign irq_pend    = rx_pending & rx_irq_en;
  assign o_irq_take  = irq_pend & i_int_en & ~i_in_irq & irq_armed;
  assign o_irq_vector = IRQ_VECTOR;
  assign bus.o_rdy   = 1'b1;
  assign unused_bits = ^{bus.i_wdata[15:8], bus.i_addr[0]};

  mmio_periph_bus_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .tx_start   (wr && (reg_sel == REG_UART_DATA) && !tx_busy),
    .tx_data    (bus.i_wdata[7:0]),
    .rx_clr     (wr && (reg_sel == REG_UART_STAT) && bus.i_wdata[STAT_RX_PEND]),
    .tx_busy    (tx_busy),
    .rx_pending (rx_pending),
    .rx_data    (rx_data),
    .i_uart_rx  (i_uart_rx),
    .o_uart_tx  (o_uart_tx)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_par_o   <= '0;
      rx_irq_en <= 1'b0;
      irq_armed <= 1'b1;
    end else begin
      if (wr && (reg_sel == REG_PAR_OUT))   o_par_o   <= bus.i_wdata[3:0];
      if (wr && (reg_sel == REG_UART_CTRL)) rx_irq_en <= bus.i_wdata[0];
      if (o_irq_take)     irq_armed <= 1'b0;
      else if (i_irq_ret) irq_armed <= 1'b1;
    end
  end

  always_comb begin
    bus.o_rdata = '0;
    if (rd) begin
      case (reg_sel)
        REG_PAR_IN:    bus.o_rdata[3:0] = i_par_i;
        REG_PAR_OUT:   bus.o_rdata[3:0] = o_par_o;
        REG_UART_DATA: bus.o_rdata[7:0] = rx_data;
        REG_UART_STAT: begin
          bus.o_rdata[STAT_TX_BUSY] = tx_busy;
          bus.o_rdata[STAT_RX_PEND] = rx_pending;
        end
        REG_UART_CTRL: bus.o_rdata[0] = rx_irq_en;
        REG_IRQ_STAT:  bus.o_rdata[0] = irq_pend;
        default:       bus.o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_periph_bus.sv
// Directed bench for mmio_periph_bus: register map, UART TX/RX, IRQ handshake, reset.
module tb_mmio_periph_bus;
  import mmio_periph_bus_pkg::*;

  localparam int unsigned CPB = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [3:0]  i_par_i = '0;
  logic [3:0]  o_par_o;
  logic        i_uart_rx = 1'b1;
  logic        o_uart_tx;
  logic        i_in_irq = 1'b0;
  logic        i_int_en = 1'b0;
  logic        i_irq_ret = 1'b0;
  logic        o_irq_take;
  logic [15:0] o_irq_vector;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  mmio_periph_bus_if bus ();

  mmio_periph_bus #(.CLKS_PER_BIT(CPB), .IRQ_VECTOR(16'h0010)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .bus          (bus),
    .i_par_i      (i_par_i),
    .o_par_o      (o_par_o),
    .i_uart_rx    (i_uart_rx),
    .o_uart_tx    (o_uart_tx),
    .i_in_irq     (i_in_irq),
    .i_int_en     (i_int_en),
    .i_irq_ret    (i_irq_ret),
    .o_irq_take   (o_irq_take),
    .o_irq_vector (o_irq_vector)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge i_clk);
    bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = addr; bus.i_wdata = data;
    @(posedge i_clk);
    #1;
    bus.i_sel = 1'b0; bus.i_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge i_clk);
    bus.i_sel = 1'b1; bus.i_re = 1'b1; bus.i_addr = addr;
    #1;
    data = bus.o_rdata;
    bus.i_sel = 1'b0; bus.i_re = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      repeat (CPB) @(negedge i_clk);
    end
    i_uart_rx = stop_bit;
    repeat (CPB) @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [9:0]  frame;
    logic        cleared;

    bus.i_sel = 1'b0; bus.i_we = 1'b0; bus.i_re = 1'b0;
    bus.i_addr = '0; bus.i_wdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;

    // Reset state
    check("rst_par_o", {12'h0, o_par_o}, 16'h0000);
    check("rst_tx", {15'h0, o_uart_tx}, 16'h0001);
    check("rst_take", {15'h0, o_irq_take}, 16'h0000);
    check("rdy", {15'h0, bus.o_rdy}, 16'h0001);
    check("vector", o_irq_vector, 16'h0010);
    bus_read(16'h8302, d); check("rst_stat", d, 16'h0000);
    bus_read(16'h8300, d); check("rst_rxdata", d, 16'h0000);
    bus_read(16'h8304, d); check("rst_ctrl", d, 16'h0000);

    // Parallel port and decode
    bus_write(16'h8002, 16'h000C);
    check("par_o", {12'h0, o_par_o}, 16'h000C);
    bus_read(16'h8002, d); check("par_out_rd", d, 16'h000C);
    bus_read(16'h8003, d); check("par_out_rd_bit0", d, 16'h000C);
    i_par_i = 4'h3;
    bus_read(16'h8000, d); check("par_in_rd", d, 16'h0003);
    bus_read(16'h8100, d); check("unmapped_rd", d, 16'h0000);
    bus_write(16'h8200, 16'hFFFF);
    check("unmapped_wr", {12'h0, o_par_o}, 16'h000C);

    // UART TX of 0x5A: write edge E, bit i is centred around edge E+8+16*i
    bus_write(16'h8300, 16'h005A);
    bus_read(16'h8302, d); check("tx_busy_set", d, 16'h0001);
    repeat (CPB / 2) @(posedge i_clk);
    #1 frame[0] = o_uart_tx;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(posedge i_clk);
      #1 frame[i] = o_uart_tx;
    end
    check("tx_frame", {6'h0, frame}, {6'h0, 1'b1, 8'h5A, 1'b0});
    cleared = 1'b0;
    for (int k = 0; k < 12 && !cleared; k++) begin
      bus_read(16'h8302, d);
      if (!d[0]) cleared = 1'b1;
    end
    check("tx_busy_clear", {15'h0, cleared}, 16'h0001);
    check("tx_idle", {15'h0, o_uart_tx}, 16'h0001);

    // Forced pending flag, then W1C
    @(negedge i_clk);
    force dut.u_uart._rx_pending = 1'b1;
    bus_read(16'h8302, d); check("forced_pend", d, 16'h0002);
    release dut.u_uart._rx_pending;
    bus_write(16'h8302, 16'h0002);
    bus_read(16'h8302, d); check("w1c_pend", d, 16'h0000);

    // RX frame 0xA5
    send_rx(8'hA5, 1'b1);
    bus_read(16'h8302, d); check("rx_pend", d, 16'h0002);
    bus_read(16'h8300, d); check("rx_data", d, 16'h00A5);

    // IRQ handshake
    check("irq_disabled", {15'h0, o_irq_take}, 16'h0000);
    bus_write(16'h8304, 16'h0001);
    bus_read(16'h8304, d); check("ctrl_rd", d, 16'h0001);
    bus_read(16'h8306, d); check("irq_stat", d, 16'h0001);
    check("irq_no_gie", {15'h0, o_irq_take}, 16'h0000);
    @(negedge i_clk);
    i_int_en = 1'b1;
    #1 check("irq_take", {15'h0, o_irq_take}, 16'h0001);
    check("irq_vector", o_irq_vector, 16'h0010);
    @(posedge i_clk);
    #1 check("irq_disarmed", {15'h0, o_irq_take}, 16'h0000);
    repeat (2) @(posedge i_clk);
    #1 check("irq_no_retake", {15'h0, o_irq_take}, 16'h0000);
    @(negedge i_clk);
    i_irq_ret = 1'b1;
    @(posedge i_clk);
    #1 i_irq_ret = 1'b0;
    check("irq_rearmed", {15'h0, o_irq_take}, 16'h0001);
    i_in_irq = 1'b1;
    #1 check("irq_in_handler", {15'h0, o_irq_take}, 16'h0000);
    i_int_en = 1'b0;
    i_in_irq = 1'b0;
    bus_write(16'h8302, 16'h0002);
    bus_read(16'h8306, d); check("irq_stat_clr", d, 16'h0000);

    // Bad stop bit drops the frame
    send_rx(8'h3C, 1'b0);
    bus_read(16'h8302, d); check("badstop_pend", d, 16'h0000);
    bus_read(16'h8300, d); check("badstop_data", d, 16'h00A5);

    // Reset in the middle of a TX frame
    bus_write(16'h8002, 16'h0005);
    bus_write(16'h8300, 16'h0033);
    repeat (40) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("rst_mid_tx", {15'h0, o_uart_tx}, 16'h0001);
    check("rst_mid_par", {12'h0, o_par_o}, 16'h0000);
    bus_read(16'h8302, d); check("rst_mid_stat", d, 16'h0000);
    bus_read(16'h8304, d); check("rst_mid_ctrl", d, 16'h0000);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 check("post_rst_tx", {15'h0, o_uart_tx}, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
